issue_dispatch: RTL and testbench

ISSUE_DISPATCH -- requirements
Module: issue_dispatch

---
 rtl/spu_pkg.sv | 58 +++++
 rtl/instr_classify.sv | 76 +++++++
 rtl/issue_dispatch.sv | 137 +++++++++++++
 tb/tb_issue_dispatch.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared types and opcode constants for the SPU dual-issue front end.
// Pipe classes, the per-instruction class bundle, and the pair-conflict rule.
package spu_pkg;

  localparam int WORD = 32;

  localparam logic [10:0] OP_A    = 11'b00011000000;
  localparam logic [8:0]  OP_IL   = 9'b010000001;
  localparam logic [7:0]  OP_LQD  = 8'b00110100;
  localparam logic [7:0]  OP_STQD = 8'b00100100;
  localparam logic [8:0]  OP_BR   = 9'b001100100;
  localparam logic [10:0] OP_STOP = 11'b00000000000;
  localparam logic [10:0] OP_LNOP = 11'b00000000001;
  localparam logic [10:0] OP_NOP  = 11'b01000000001;

  typedef enum logic [1:0] {
    EVEN = 2'd0,
    ODD  = 2'd1,
    NOOP = 2'd2
  } pipe_e;

  typedef enum logic {
    S_PAIR   = 1'b0,
    S_SECOND = 1'b1
  } state_e;

  // rc is the rt field when it is read as a source.
  typedef struct packed {
    pipe_e      pipe;
    logic       writes_rt;
    logic       is_branch;
    logic       ra_v;
    logic [6:0] ra;
    logic       rb_v;
    logic [6:0] rb;
    logic       rc_v;
    logic [6:0] rc;
    logic [6:0] rt;
  } instr_class_t;

  // Older slot a, younger slot b.
  function automatic logic pair_conflict(
    input instr_class_t a,
    input instr_class_t b
  );
    logic same_pipe;
    logic raw;
    same_pipe = (a.pipe != NOOP) && (b.pipe != NOOP)
             && (a.pipe == b.pipe);
    raw = a.writes_rt && (
            (b.ra_v && (b.ra == a.rt))
         || (b.rb_v && (b.rb == a.rt))
         || (b.rc_v && (b.rc == a.rt))
         || (b.writes_rt && (b.rt == a.rt)));
    return same_pipe || raw || a.is_branch;
  endfunction

endpackage

// File: rtl/instr_classify.sv
// Decodes one instruction word into its pipe and register usage.
// Bit 0 is the MSB, so field [25:31] is instr[6:0].
module instr_classify
  import spu_pkg::*;
(
  input  logic [WORD-1:0] instr,
  output instr_class_t    cls
);

  logic [10:0] op11;
  logic [8:0]  op9;
  logic [7:0]  op8;

  assign op11 = instr[31:21];
  assign op9  = instr[31:23];
  assign op8  = instr[31:24];

  // Field extraction plus opcode-driven class; unknown opcodes read all three.
  always_comb begin
    cls           = '0;
    cls.ra        = instr[13:7];
    cls.rb        = instr[20:14];
    cls.rc        = instr[6:0];
    cls.rt        = instr[6:0];
    cls.pipe      = EVEN;
    cls.writes_rt = 1'b1;
    cls.ra_v      = 1'b1;
    cls.rb_v      = 1'b1;
    cls.rc_v      = 1'b1;
    unique case (1'b1)
      (op11 == OP_A): begin
        cls.rc_v = 1'b0;
      end
      (op9 == OP_IL): begin
        cls.ra_v = 1'b0;
        cls.rb_v = 1'b0;
        cls.rc_v = 1'b0;
      end
      (op8 == OP_LQD): begin
        cls.pipe = ODD;
        cls.rb_v = 1'b0;
        cls.rc_v = 1'b0;
      end
      (op8 == OP_STQD): begin
        cls.pipe      = ODD;
        cls.writes_rt = 1'b0;
        cls.rb_v      = 1'b0;
      end
      (op9 == OP_BR): begin
        cls.pipe      = ODD;
        cls.writes_rt = 1'b0;
        cls.is_branch = 1'b1;
        cls.ra_v      = 1'b0;
        cls.rb_v      = 1'b0;
        cls.rc_v      = 1'b0;
      end
      (op11 == OP_STOP): begin
        cls.pipe      = ODD;
        cls.writes_rt = 1'b0;
        cls.ra_v      = 1'b0;
        cls.rb_v      = 1'b0;
        cls.rc_v      = 1'b0;
      end
      (op11 == OP_LNOP),
      (op11 == OP_NOP): begin
        cls.pipe      = NOOP;
        cls.writes_rt = 1'b0;
        cls.ra_v      = 1'b0;
        cls.rb_v      = 1'b0;
        cls.rc_v      = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/issue_dispatch.sv
// Dual-issue dispatcher: routes a fetched pair to even/odd pipes, splitting conflicts.
// Optional ISSUE_STATS_EN adds saturating dual_cnt / split_cnt outputs.
module issue_dispatch
  import spu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [WORD-1:0] instr1,
  input  logic [WORD-1:0] instr2,
  input  logic            pair_valid,
  input  logic            issue_stall,
  input  logic            flush,
  output logic            dep_stall_instr2,
  output logic [WORD-1:0] even_instr,
  output logic [WORD-1:0] odd_instr,
  output logic            even_valid,
`ifdef ISSUE_STATS_EN
  output logic            odd_valid,
  output logic [31:0]     dual_cnt,
  output logic [31:0]     split_cnt
`else
  output logic            odd_valid
`endif
);

  instr_class_t c1;
  instr_class_t c2;
  logic         conflict;
  logic         dep;

  state_e          state_q, state_d;
  logic            even_valid_q, even_valid_d;
  logic            odd_valid_q, odd_valid_d;
  logic [WORD-1:0] even_instr_q, even_instr_d;
  logic [WORD-1:0] odd_instr_q, odd_instr_d;

  instr_classify u_cls1 (.instr(instr1), .cls(c1));
  instr_classify u_cls2 (.instr(instr2), .cls(c2));

  assign conflict = pair_conflict(c1, c2);

  // Issue decision: flush beats stall beats second-slot issue beats new pair.
  always_comb begin
    state_d      = state_q;
    even_valid_d = 1'b0;
    odd_valid_d  = 1'b0;
    even_instr_d = even_instr_q;
    odd_instr_d  = odd_instr_q;
    dep          = 1'b0;
    if (flush) begin
      state_d = S_PAIR;
    end else if (issue_stall) begin
      dep = 1'b1;
    end else if (state_q == S_SECOND) begin
      state_d = S_PAIR;
      if (c2.pipe == EVEN) begin
        even_valid_d = 1'b1;
        even_instr_d = instr2;
      end else if (c2.pipe == ODD) begin
        odd_valid_d = 1'b1;
        odd_instr_d = instr2;
      end
    end else if (pair_valid) begin
      if (c1.pipe == EVEN) begin
        even_valid_d = 1'b1;
        even_instr_d = instr1;
      end else if (c1.pipe == ODD) begin
        odd_valid_d = 1'b1;
        odd_instr_d = instr1;
      end
      if (conflict) begin
        dep     = 1'b1;
        state_d = S_SECOND;
      end else if (c2.pipe == EVEN) begin
        even_valid_d = 1'b1;
        even_instr_d = instr2;
      end else if (c2.pipe == ODD) begin
        odd_valid_d = 1'b1;
        odd_instr_d = instr2;
      end
    end
  end

  // State and issue registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_PAIR;
      even_valid_q <= 1'b0;
      odd_valid_q  <= 1'b0;
      even_instr_q <= '0;
      odd_instr_q  <= '0;
    end else begin
      state_q      <= state_d;
      even_valid_q <= even_valid_d;
      odd_valid_q  <= odd_valid_d;
      even_instr_q <= even_instr_d;
      odd_instr_q  <= odd_instr_d;
    end
  end

  assign dep_stall_instr2 = dep && !reset;
  assign even_valid       = even_valid_q;
  assign odd_valid        = odd_valid_q;
  assign even_instr       = even_instr_q;
  assign odd_instr        = odd_instr_q;

`ifdef ISSUE_STATS_EN
  logic [31:0] dual_cnt_q, dual_cnt_d;
  logic [31:0] split_cnt_q, split_cnt_d;

  // Saturating counters; only a non-split pair can fill both pipes at once.
  always_comb begin
    dual_cnt_d  = dual_cnt_q;
    split_cnt_d = split_cnt_q;
    if (even_valid_d && odd_valid_d && (dual_cnt_q != '1))
      dual_cnt_d = dual_cnt_q + 32'd1;
    if ((state_q == S_PAIR) && (state_d == S_SECOND)
        && (split_cnt_q != '1))
      split_cnt_d = split_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dual_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else begin
      dual_cnt_q  <= dual_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign dual_cnt  = dual_cnt_q;
  assign split_cnt = split_cnt_q;
`endif

endmodule

// File: tb/tb_issue_dispatch.sv
// Bench for issue_dispatch: directed pairs, then random traffic vs a reference model.
// Build with ISSUE_STATS_EN to also check the counters.
module tb_issue_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr1;
  logic [31:0] instr2;
  logic        pair_valid;
  logic        issue_stall;
  logic        flush;
  logic        dep_stall_instr2;
  logic [31:0] even_instr;
  logic [31:0] odd_instr;
  logic        even_valid;
  logic        odd_valid;
`ifdef ISSUE_STATS_EN
  logic [31:0] dual_cnt;
  logic [31:0] split_cnt;
`endif

  issue_dispatch dut (
    .clk             (clk),
    .reset           (reset),
    .instr1          (instr1),
    .instr2          (instr2),
    .pair_valid      (pair_valid),
    .issue_stall     (issue_stall),
    .flush           (flush),
    .dep_stall_instr2(dep_stall_instr2),
    .even_instr      (even_instr),
    .odd_instr       (odd_instr),
    .even_valid      (even_valid),
`ifdef ISSUE_STATS_EN
    .odd_valid       (odd_valid),
    .dual_cnt        (dual_cnt),
    .split_cnt       (split_cnt)
`else
    .odd_valid       (odd_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: kinds 0 a,1 il,2 lqd,3 stqd,4 br,5 stop,6 noop,7 other.
  function automatic int kind(logic [31:0] w);
    logic [10:0] o11;
    logic [8:0]  o9;
    logic [7:0]  o8;
    o11 = w[31:21];
    o9  = w[31:23];
    o8  = w[31:24];
    if (o11 == 11'b00011000000) return 0;
    if (o9 == 9'b010000001) return 1;
    if (o8 == 8'b00110100) return 2;
    if (o8 == 8'b00100100) return 3;
    if (o9 == 9'b001100100) return 4;
    if (o11 == 11'd0) return 5;
    if (o11 == 11'd1 || o11 == 11'b01000000001) return 6;
    return 7;
  endfunction

  // 0 even, 1 odd, 2 none
  function automatic int pipe_of(logic [31:0] w);
    int k;
    k = kind(w);
    if (k == 6) return 2;
    if (k >= 2 && k <= 5) return 1;
    return 0;
  endfunction

  function automatic int dst(logic [31:0] w);
    int k;
    k = kind(w);
    if (k == 0 || k == 1 || k == 2 || k == 7) return int'(w[6:0]);
    return -1;
  endfunction

  function automatic bit reads(logic [31:0] w, int r);
    int k;
    int ra;
    int rb;
    int rt;
    k  = kind(w);
    ra = int'(w[13:7]);
    rb = int'(w[20:14]);
    rt = int'(w[6:0]);
    case (k)
      0: return (ra == r) || (rb == r);
      2: return ra == r;
      3: return (ra == r) || (rt == r);
      7: return (ra == r) || (rb == r) || (rt == r);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit conflict(logic [31:0] w1, logic [31:0] w2);
    int p1;
    int p2;
    int d1;
    p1 = pipe_of(w1);
    p2 = pipe_of(w2);
    d1 = dst(w1);
    if (p1 != 2 && p1 == p2) return 1'b1;
    if (d1 >= 0 && (reads(w2, d1) || dst(w2) == d1)) return 1'b1;
    return kind(w1) == 4;
  endfunction

  bit          pend;
  bit          m_ev;
  bit          m_ov;
  logic [31:0] m_ei;
  logic [31:0] m_oi;
  logic [31:0] m_dual;
  logic [31:0] m_split;
  bit          last_dep;

  task automatic issue_m(logic [31:0] w);
    int p;
    p = pipe_of(w);
    if (p == 0) begin
      m_ev = 1'b1;
      m_ei = w;
    end else if (p == 1) begin
      m_ov = 1'b1;
      m_oi = w;
    end
  endtask

  task automatic drive(bit r, bit pv, logic [31:0] i1, logic [31:0] i2,
                       bit st, bit fl);
    bit c;
    bit d;
    reset       = r;
    pair_valid  = pv;
    instr1      = i1;
    instr2      = i2;
    issue_stall = st;
    flush       = fl;
    #1;
    c = conflict(i1, i2);
    d = !r && !fl && (st || (!pend && pv && c));
    check("dep_stall", {31'd0, dep_stall_instr2}, {31'd0, d});
    last_dep = d;
    m_ev = 1'b0;
    m_ov = 1'b0;
    if (r) begin
      pend    = 1'b0;
      m_ei    = '0;
      m_oi    = '0;
      m_dual  = '0;
      m_split = '0;
    end else if (fl) begin
      pend = 1'b0;
    end else if (st) begin
    end else if (pend) begin
      issue_m(i2);
      pend = 1'b0;
    end else if (pv) begin
      issue_m(i1);
      if (c) begin
        pend = 1'b1;
        if (m_split != 32'hFFFF_FFFF) m_split++;
      end else begin
        issue_m(i2);
        if (m_ev && m_ov && m_dual != 32'hFFFF_FFFF) m_dual++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("even_valid", {31'd0, even_valid}, {31'd0, m_ev});
    check("odd_valid", {31'd0, odd_valid}, {31'd0, m_ov});
    if (m_ev || r) check("even_instr", even_instr, m_ei);
    if (m_ov || r) check("odd_instr", odd_instr, m_oi);
`ifdef ISSUE_STATS_EN
    check("dual_cnt", dual_cnt, m_dual);
    check("split_cnt", split_cnt, m_split);
`endif
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ra;
    logic [6:0]  rb;
    logic [6:0]  rt;
    int          k;
    w  = $urandom;
    ra = 7'($urandom_range(0, 7));
    rb = 7'($urandom_range(0, 7));
    rt = 7'($urandom_range(0, 7));
    k  = $urandom_range(0, 8);
    case (k)
      0: w[31:21] = 11'b00011000000;
      1: w[31:23] = 9'b010000001;
      2: w[31:24] = 8'b00110100;
      3: w[31:24] = 8'b00100100;
      4: w[31:23] = 9'b001100100;
      5: w[31:21] = 11'd0;
      6: w[31:21] = 11'd1;
      7: w[31:21] = 11'b01000000001;
      default: w[31] = 1'b1;
    endcase
    w[20:14] = rb;
    w[13:7]  = ra;
    w[6:0]   = rt;
    return w;
  endfunction

  initial begin
    logic [31:0] a1;
    logic [31:0] a2;
    bit          pv;
    pend     = 1'b0;
    last_dep = 1'b0;
    m_ei     = '0;
    m_oi     = '0;
    m_dual   = '0;
    m_split  = '0;
    reset = 1'b1; pair_valid = 1'b0; issue_stall = 1'b0; flush = 1'b0;
    instr1 = '0; instr2 = '0;
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h18008083, 32'h34000284, 0, 0);
    // clean dual issue
    drive(0, 1, 32'h18008083, 32'h34000284, 0, 0);
    check("dual_even", even_instr, 32'h18008083);
    check("dual_odd", odd_instr, 32'h34000284);
    // RAW split
    drive(0, 1, 32'h18008083, 32'h34000184, 0, 0);
    drive(0, 1, 32'h18008083, 32'h34000184, 0, 0);
    check("raw_second", odd_instr, 32'h34000184);
    // same pipe split
    drive(0, 1, 32'h18008083, 32'h18008086, 0, 0);
    drive(0, 1, 32'h18008083, 32'h18008086, 0, 0);
    check("even_second", even_instr, 32'h18008086);
    // lnop + lqd
    drive(0, 1, 32'h00200000, 32'h34000284, 0, 0);
    // nothing valid
    drive(0, 0, 32'h18008083, 32'h34000284, 0, 0);
    // flush in SECOND
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h18008083, 32'h34000184, 0, 0);
    drive(0, 1, 32'h18008083, 32'h34000184, 0, 1);
    drive(0, 1, 32'h18008083, 32'h34000284, 0, 0);
    // stall in PAIR then in SECOND
    drive(0, 1, 32'h18008083, 32'h34000184, 1, 0);
    drive(0, 1, 32'h18008083, 32'h34000184, 0, 0);
    drive(0, 1, 32'h18008083, 32'h34000184, 1, 0);
    drive(0, 1, 32'h18008083, 32'h34000184, 0, 0);
    // reset in SECOND drops instr2
    drive(0, 1, 32'h18008083, 32'h34000184, 0, 0);
    drive(1, 1, 32'h18008083, 32'h34000184, 0, 0);
    drive(0, 0, 32'h18008083, 32'h34000184, 0, 0);
    // branch first
    drive(0, 1, 32'h32000000, 32'h18008083, 0, 0);
    drive(0, 1, 32'h32000000, 32'h18008083, 0, 0);
    // random traffic; fetch holds the pair while dep_stall was high
    a1 = rand_instr();
    a2 = rand_instr();
    pv = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!last_dep) begin
        a1 = rand_instr();
        a2 = rand_instr();
        pv = ($urandom_range(0, 7) != 0);
      end
      drive(($urandom_range(0, 59) == 0), pv, a1, a2,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
